plab5_mcore_mem_acc_resp: RTL and testbench

Response-side security gate paired with the request-side memory access controller, placed between the network endpoint and a memory bank. Forwards permitted requests to memory and records every accepted request, permitted or denied, in an in-order tracking queue. Returns a response for every request: the memory response for permitted ones, a synthetic zero-data response for denied ones. Each response is labelled with the requester's security level, so a denied core never hangs and never sees bank data.

---
 rtl/plab5_mcore_mem_acc_resp_pkg.sv | 12 +
 rtl/plab5_mcore_mem_acc_tagq.sv | 58 +++++
 rtl/plab5_mcore_mem_acc_resp.sv | 124 ++++++++++++
 tb/tb_plab5_mcore_mem_acc_resp.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plab5_mcore_mem_acc_resp_pkg.sv
// Shared field geometry for the memory access response gate and its tag queue.
package plab5_mcore_mem_acc_resp_pkg;

  localparam int TYPE_NBITS = 3;
  localparam int LEN_NBITS  = 2;

  // Tag entry is {lvl, denied, type, opaque}.
  function automatic int tag_nbits(input int opaque_nbits);
    return 2 + TYPE_NBITS + opaque_nbits;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_acc_tagq.sv
// In-order circular queue of per-request tags; full/empty come from a count
// register so the pointers can wrap freely.
module plab5_mcore_mem_acc_tagq #(
  parameter int p_num_entries = 4,
  parameter int p_nbits       = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [p_nbits-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [p_nbits-1:0] head
);

  localparam int          PW    = $clog2(p_num_entries);
  localparam logic [PW:0] DEPTH = (PW+1)'(p_num_entries);

  logic [p_nbits-1:0] entries [p_num_entries];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        count;
  logic               push_en;
  logic               pop_en;

  // A full queue refuses a push even when a pop happens in the same cycle.
  always_comb begin
    full    = (count == DEPTH);
    empty   = (count == '0);
    push_en = push && !full;
    pop_en  = pop && !empty;
    head    = entries[rd_ptr];
  end

  // Entry storage; contents of empty slots are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) entries[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/plab5_mcore_mem_acc_resp.sv
// Security gate between the network endpoint and a memory bank. Permitted
// requests pass to memory; denied ones are answered locally with zero data.
// Every accepted request is tagged in order so responses keep request order.
module plab5_mcore_mem_acc_resp
  import plab5_mcore_mem_acc_resp_pkg::*;
#(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_num_entries  = 4,
  parameter int req_cnbits     = 3 + p_opaque_nbits + p_addr_nbits + 2,
  parameter int resp_cnbits    = 3 + p_opaque_nbits + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_sec_level,
  input  logic                    mem_sec_level,
  input  logic [req_cnbits-1:0]   net_req_control,
  input  logic [p_data_nbits-1:0] net_req_data,
  input  logic                    net_req_val,
  output logic                    net_req_rdy,
  output logic [req_cnbits-1:0]   mem_req_control,
  output logic [p_data_nbits-1:0] mem_req_data,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  input  logic [resp_cnbits-1:0]  mem_resp_control,
  input  logic [p_data_nbits-1:0] mem_resp_data,
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,
  output logic [resp_cnbits-1:0]  net_resp_control,
  output logic [p_data_nbits-1:0] net_resp_data,
  output logic                    net_resp_val,
  input  logic                    net_resp_rdy,
  output logic                    resp_sec_level,
  output logic [15:0]             deny_count,
  output logic                    err_orphan
);

  localparam int TW = tag_nbits(p_opaque_nbits);

  logic                      deny;
  logic                      accept;
  logic                      q_full;
  logic                      q_empty;
  logic                      q_pop;
  logic [TW-1:0]             q_push_data;
  logic [TW-1:0]             q_head;
  logic [TYPE_NBITS-1:0]     req_type;
  logic [p_opaque_nbits-1:0] req_opaque;
  logic                      head_lvl;
  logic                      head_denied;
  logic [TYPE_NBITS-1:0]     head_type;
  logic [p_opaque_nbits-1:0] head_opaque;
  logic                      head_perm;

  // Deny decision and request pass-through; denied payloads never reach memory.
  // An unknown requester level is treated as untrusted.
  always_comb begin
    deny            = (req_sec_level < mem_sec_level) || $isunknown(req_sec_level);
    req_type        = net_req_control[req_cnbits-1 -: TYPE_NBITS];
    req_opaque      = net_req_control[p_addr_nbits+LEN_NBITS +: p_opaque_nbits];
    net_req_rdy     = reset && !q_full && (deny || mem_req_rdy);
    mem_req_val     = reset && net_req_val && !deny && !q_full;
    mem_req_control = deny ? '0 : net_req_control;
    mem_req_data    = deny ? '0 : net_req_data;
    accept          = net_req_val && net_req_rdy;
    q_push_data     = {req_sec_level, deny, req_type, req_opaque};
  end

  plab5_mcore_mem_acc_tagq #(
    .p_num_entries (p_num_entries),
    .p_nbits       (TW)
  ) tagq (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (q_push_data),
    .pop       (q_pop),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  // Response mux: synthesize a zero-data reply for a denied head, otherwise
  // connect memory straight through to the network.
  always_comb begin
    {head_lvl, head_denied, head_type, head_opaque} = q_head;
    head_perm        = !q_empty && !head_denied;
    net_resp_val     = 1'b0;
    net_resp_control = '0;
    net_resp_data    = '0;
    mem_resp_rdy     = 1'b0;
    resp_sec_level   = 1'b0;
    if (!q_empty) begin
      resp_sec_level = head_lvl;
      if (head_denied) begin
        net_resp_val     = 1'b1;
        net_resp_control = {head_type, head_opaque, {LEN_NBITS{1'b0}}};
      end else begin
        net_resp_val     = mem_resp_val;
        net_resp_control = mem_resp_control;
        net_resp_data    = mem_resp_data;
        mem_resp_rdy     = net_resp_rdy;
      end
    end
    if (!reset) begin
      net_resp_val = 1'b0;
      mem_resp_rdy = 1'b0;
    end
    q_pop = net_resp_val && net_resp_rdy;
  end

  // Saturating denial counter and sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      deny_count <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept && deny && deny_count != 16'hFFFF) deny_count <= deny_count + 16'd1;
      if (mem_resp_val && !head_perm) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_acc_resp.sv
// Bench: directed scenarios plus randomized traffic, with a queue-based model
// compared against every output on every falling edge.
module tb_plab5_mcore_mem_acc_resp;

  localparam int O  = 8;
  localparam int A  = 32;
  localparam int D  = 32;
  localparam int N  = 4;
  localparam int RC = 3 + O + A + 2;
  localparam int SC = 3 + O + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_sec_level, mem_sec_level;
  logic [RC-1:0] net_req_control;
  logic [D-1:0]  net_req_data;
  logic          net_req_val, net_req_rdy;
  logic [RC-1:0] mem_req_control;
  logic [D-1:0]  mem_req_data;
  logic          mem_req_val, mem_req_rdy;
  logic [SC-1:0] mem_resp_control;
  logic [D-1:0]  mem_resp_data;
  logic          mem_resp_val, mem_resp_rdy;
  logic [SC-1:0] net_resp_control;
  logic [D-1:0]  net_resp_data;
  logic          net_resp_val, net_resp_rdy;
  logic          resp_sec_level;
  logic [15:0]   deny_count;
  logic          err_orphan;

  always #5 clk = ~clk;

  plab5_mcore_mem_acc_resp dut (
    .clk(clk), .reset(reset),
    .req_sec_level(req_sec_level), .mem_sec_level(mem_sec_level),
    .net_req_control(net_req_control), .net_req_data(net_req_data),
    .net_req_val(net_req_val), .net_req_rdy(net_req_rdy),
    .mem_req_control(mem_req_control), .mem_req_data(mem_req_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_resp_control(mem_resp_control), .mem_resp_data(mem_resp_data),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .net_resp_control(net_resp_control), .net_resp_data(net_resp_data),
    .net_resp_val(net_resp_val), .net_resp_rdy(net_resp_rdy),
    .resp_sec_level(resp_sec_level), .deny_count(deny_count),
    .err_orphan(err_orphan)
  );

  typedef struct {
    bit       lvl;
    bit       denied;
    bit [2:0] typ;
    bit [7:0] opq;
  } ent_t;

  ent_t mq[$];        // outstanding requests in accept order
  ent_t mem_pend[$];  // permitted requests the bench memory still owes
  int   m_cnt;
  bit   m_orph;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: check this cycle's outputs, then advance to the next edge.
  always @(negedge clk) begin : cmp
    bit            deny, full, empty, e_rdy, e_mval, e_rval, e_mrrdy, e_lvl;
    logic [RC-1:0] e_mctl;
    logic [D-1:0]  e_mdata;
    logic [SC-1:0] e_rctl;
    logic [D-1:0]  e_rdata;
    ent_t          ne;
    if (!reset) begin
      chk("rst_net_req_rdy", net_req_rdy, 0);
      chk("rst_mem_req_val", mem_req_val, 0);
      chk("rst_mem_resp_rdy", mem_resp_rdy, 0);
      chk("rst_net_resp_val", net_resp_val, 0);
      mq.delete();
      mem_pend.delete();
      m_cnt  = 0;
      m_orph = 0;
    end else begin
      deny    = req_sec_level < mem_sec_level;
      full    = mq.size() == N;
      empty   = mq.size() == 0;
      e_rdy   = !full && (deny || mem_req_rdy);
      e_mval  = net_req_val && !deny && !full;
      e_mctl  = deny ? '0 : net_req_control;
      e_mdata = deny ? '0 : net_req_data;
      e_rval  = 0; e_rctl = '0; e_rdata = '0; e_mrrdy = 0; e_lvl = 0;
      if (!empty) begin
        e_lvl = mq[0].lvl;
        if (mq[0].denied) begin
          e_rval = 1;
          e_rctl = {mq[0].typ, mq[0].opq, 2'b00};
        end else begin
          e_rval  = mem_resp_val;
          e_rctl  = mem_resp_control;
          e_rdata = mem_resp_data;
          e_mrrdy = net_resp_rdy;
        end
      end
      chk("net_req_rdy", net_req_rdy, e_rdy);
      chk("mem_req_val", mem_req_val, e_mval);
      chk("mem_req_control", mem_req_control, e_mctl);
      chk("mem_req_data", mem_req_data, e_mdata);
      chk("net_resp_val", net_resp_val, e_rval);
      chk("mem_resp_rdy", mem_resp_rdy, e_mrrdy);
      chk("resp_sec_level", resp_sec_level, e_lvl);
      chk("deny_count", deny_count, 64'(m_cnt));
      chk("err_orphan", err_orphan, m_orph);
      if (e_rval) begin
        chk("net_resp_control", net_resp_control, e_rctl);
        chk("net_resp_data", net_resp_data, e_rdata);
      end
      // next state
      if (mem_resp_val && (empty || mq[0].denied)) m_orph = 1;
      if (e_rval && net_resp_rdy) begin
        if (!mq[0].denied) void'(mem_pend.pop_front());
        void'(mq.pop_front());
      end
      if (net_req_val && e_rdy) begin
        ne.lvl    = req_sec_level;
        ne.denied = deny;
        ne.typ    = net_req_control[RC-1 -: 3];
        ne.opq    = net_req_control[A+2 +: O];
        mq.push_back(ne);
        if (deny) begin
          if (m_cnt < 16'hFFFF) m_cnt++;
        end else mem_pend.push_back(ne);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    net_req_val      = 0;
    mem_resp_val     = 0;
    mem_resp_control = '0;
    mem_resp_data    = '0;
  endtask

  task automatic send(input bit lvl, input bit [2:0] t, input bit [7:0] op, input bit [31:0] d);
    net_req_val     = 1;
    req_sec_level   = lvl;
    net_req_control = {t, op, 32'h1000 + 32'(op), 2'b00};
    net_req_data    = d;
  endtask

  task automatic mresp(input bit [7:0] op, input bit [31:0] d);
    mem_resp_val     = 1;
    mem_resp_control = {3'd0, op, 2'b00};
    mem_resp_data    = d;
  endtask

  initial begin
    logic [RC-1:0] exp_ctl;
    reset = 0; idle();
    net_resp_rdy = 1; mem_req_rdy = 1;
    mem_sec_level = 0; req_sec_level = 0;
    net_req_control = '0; net_req_data = '0;
    step(); step();
    reset = 1;
    @(negedge clk);
    chk("init_deny_count", deny_count, 0);
    chk("init_err_orphan", err_orphan, 0);
    chk("init_net_resp_val", net_resp_val, 0);

    // Permitted read
    step();
    mem_sec_level = 1;
    send(1, 3'd0, 8'h05, 32'h0);
    exp_ctl = {3'd0, 8'h05, 32'h1005, 2'b00};
    @(negedge clk);
    chk("p_mem_req_val", mem_req_val, 1);
    chk("p_mem_req_ctl", mem_req_control, exp_ctl);
    step();
    idle();
    mresp(8'h05, 32'hCAFE0001);
    @(negedge clk);
    chk("p_resp_val", net_resp_val, 1);
    chk("p_resp_data", net_resp_data, 32'hCAFE0001);
    chk("p_resp_opq", net_resp_control[9:2], 8'h05);
    chk("p_resp_lvl", resp_sec_level, 1);
    chk("p_deny_cnt", deny_count, 0);
    step();
    idle();

    // Denied write
    send(0, 3'd1, 8'h22, 32'hDEADBEEF);
    @(negedge clk);
    chk("d_mem_req_val", mem_req_val, 0);
    chk("d_mem_req_data", mem_req_data, 0);
    chk("d_resp_early", net_resp_val, 0);
    step();
    idle();
    @(negedge clk);
    chk("d_resp_val", net_resp_val, 1);
    chk("d_resp_ctl", net_resp_control, 13'b001_00100010_00);
    chk("d_resp_data", net_resp_data, 0);
    chk("d_resp_lvl", resp_sec_level, 0);
    chk("d_deny_cnt", deny_count, 1);
    step();

    // P0, D1, P2 with memory holding P0 back
    send(1, 3'd0, 8'h00, 32'h0); step();
    send(0, 3'd0, 8'h01, 32'h0); step();
    send(1, 3'd0, 8'h02, 32'h0); step();
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("il_hold", net_resp_val, 0);
      step();
    end
    mresp(8'h00, 32'h11);
    @(negedge clk);
    chk("il_p0_val", net_resp_val, 1);
    chk("il_p0_opq", net_resp_control[9:2], 8'h00);
    step();
    idle();
    @(negedge clk);
    chk("il_d1_opq", net_resp_control[9:2], 8'h01);
    chk("il_d1_data", net_resp_data, 0);
    step();
    mresp(8'h02, 32'h22);
    @(negedge clk);
    chk("il_p2_opq", net_resp_control[9:2], 8'h02);
    chk("il_p2_data", net_resp_data, 32'h22);
    step();
    idle();

    // Fill with denied requests, then free exactly one slot
    net_resp_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      send(0, 3'd1, 8'h40 + 8'(i), 32'h0);
      step();
    end
    send(0, 3'd1, 8'h44, 32'h0);
    @(negedge clk);
    chk("full_rdy", net_req_rdy, 0);
    step();
    net_resp_rdy = 1;
    @(negedge clk);
    chk("full_nobypass", net_req_rdy, 0);
    chk("full_head_opq", net_resp_control[9:2], 8'h40);
    step();
    net_resp_rdy = 0;
    @(negedge clk);
    chk("full_after_pop", net_req_rdy, 1);
    step();
    idle();
    net_resp_rdy = 1;
    repeat (5) step();
    @(negedge clk);
    chk("fill_deny_cnt", deny_count, 7);
    step();

    // Memory response with nothing outstanding
    mresp(8'h99, 32'h1234);
    @(negedge clk);
    chk("orph_mem_rdy", mem_resp_rdy, 0);
    chk("orph_before", err_orphan, 0);
    step();
    idle();
    @(negedge clk);
    chk("orph_set", err_orphan, 1);
    repeat (3) step();
    @(negedge clk);
    chk("orph_sticky", err_orphan, 1);
    step();

    // Reset with three outstanding entries
    net_resp_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      send(0, 3'd1, 8'h60 + 8'(i), 32'h0);
      step();
    end
    idle();
    reset = 0;
    @(negedge clk);
    chk("rst_mid_val", net_resp_val, 0);
    step();
    reset = 1;
    net_resp_rdy = 1;
    @(negedge clk);
    chk("rst_after_val", net_resp_val, 0);
    chk("rst_after_cnt", deny_count, 0);
    chk("rst_after_orph", err_orphan, 0);
    send(0, 3'd2, 8'h77, 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("rst_new_val", net_resp_val, 1);
    chk("rst_new_opq", net_resp_control[9:2], 8'h77);
    chk("rst_new_cnt", deny_count, 1);
    step();

    // Randomized traffic with an in-order bench memory
    repeat (3000) begin
      reset           = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0) mem_sec_level = ~mem_sec_level;
      req_sec_level   = 1'($urandom);
      net_req_val     = 1'($urandom);
      net_req_control = RC'({$urandom, $urandom});
      net_req_data    = $urandom;
      mem_req_rdy     = ($urandom_range(0, 3) != 0);
      net_resp_rdy    = ($urandom_range(0, 9) < 7);
      if (mem_pend.size() > 0 && mq.size() > 0 && !mq[0].denied && $urandom_range(0, 2) != 0)
        mresp(mem_pend[0].opq, $urandom);
      else begin
        mem_resp_val     = 0;
        mem_resp_control = SC'($urandom);
        mem_resp_data    = $urandom;
      end
      step();
    end

    reset = 1;
    idle();
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
